decode_stage: RTL



---
 rtl/decode_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV instruction decode stage with a DEPTH-entry decoded-record FIFO
// Decode happens at push time; the head record is presented straight from storage.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             instr_i,
    input  logic [XLEN-1:0]         pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         out_pc_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic [6:0]              op_o,
    output logic [2:0]              funct3_o,
    output logic [6:0]              funct7_o,
    output logic [5:0]              fmt_o,
    output logic [XLEN-1:0]         imm_o,
    output logic                    illegal_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    // The raw instruction is kept so the register/opcode fields are plain slices of it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } rec_t;

    logic [5:0]  fmt_dec;
    logic [31:0] imm32;
    rec_t        rec_in;
    rec_t        head;

    rec_t        mem_q [DEPTH];
    rec_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    always_comb begin
        fmt_dec = '0;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:0])
                7'b0110011: begin
                    if (instr_i[31:25] == 7'b0000000 || instr_i[31:25] == 7'b0100000) begin
                        fmt_dec = FMT_R;
                    end
                end
                7'b0010011, 7'b0000011, 7'b1100111: fmt_dec = FMT_I;
                7'b0100011:                         fmt_dec = FMT_S;
                7'b1100011:                         fmt_dec = FMT_B;
                7'b0110111, 7'b0010111:             fmt_dec = FMT_U;
                7'b1101111:                         fmt_dec = FMT_J;
                default:                            fmt_dec = '0;
            endcase
        end
    end

    // Illegal and R-format both fall through to a zero immediate.
    always_comb begin
        imm32 = '0;
        case (fmt_dec)
            FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        rec_in         = '0;
        rec_in.pc      = pc_i;
        rec_in.instr   = instr_i;
        rec_in.fmt     = fmt_dec;
        rec_in.imm     = XLEN'($signed(imm32));
        rec_in.illegal = (fmt_dec == '0);
    end

    assign in_ready_o  = (count_q < CW'(DEPTH)) && !flush_i;
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = rec_in;
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty entries are masked at the output.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = '0;
        if (out_valid_o) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign out_pc_o  = head.pc;
    assign rs1_o     = head.instr[19:15];
    assign rs2_o     = head.instr[24:20];
    assign rd_o      = head.instr[11:7];
    assign op_o      = head.instr[6:0];
    assign funct3_o  = head.instr[14:12];
    assign funct7_o  = head.instr[31:25];
    assign fmt_o     = head.fmt;
    assign imm_o     = head.imm;
    assign illegal_o = head.illegal;
    assign count_o   = count_q;

endmodule
